// File: rtl/rs_encode_in_sequencer.sv
// rs_encode_in_sequencer
//   Feeds fixed-width input lines to an RS encoder one beat at a time.
//   A codeword is cfg_num_lines lines, with cfg_num_lines sampled on the
//   first line (0 counts as 1). Each line is cut MSB-first into
//   BEATS = LINE_W/(SYM_W*SYMS_PER_CYC) beats.
//
// Optional feature:
//   RS_IN_PREFETCH_EN - adds one prefetch line buffer so the next line can be
//                       accepted while the current one is still being fed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_line_val/_rdy   line input handshake, src_line_data the line payload
//   cfg_num_lines       lines per codeword
//   enc_start           one-cycle pulse when a codeword's first line is taken
//   enc_data_val/_rdy   beat handshake towards the encoder
//   enc_data            beat payload, symbol 0 in the top SYM_W bits
//   enc_data_last       final beat of the codeword
//   in_done             all input beats of the codeword have been issued
//   out_done            output side finished the codeword, back to IDLE
//
// state     | meaning
// IDLE      | no codeword open, waiting for its first line
// FEED      | issuing beats of the active line
// WAIT_LINE | active line fully issued, waiting for the next line
// WAIT_OUT  | all lines issued, waiting for out_done
module rs_encode_in_sequencer #(
    parameter int LINE_W       = 256,
    parameter int SYM_W        = 8,
    parameter int SYMS_PER_CYC = 1,
    parameter int LINES_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          src_line_val,
    input  logic [LINE_W-1:0]             src_line_data,
    output logic                          src_line_rdy,
    input  logic [LINES_W-1:0]            cfg_num_lines,
    output logic                          enc_start,
    output logic                          enc_data_val,
    input  logic                          enc_data_rdy,
    output logic [SYM_W*SYMS_PER_CYC-1:0] enc_data,
    output logic                          enc_data_last,
    output logic                          in_done,
    input  logic                          out_done
);

    localparam int BEAT_W = SYM_W * SYMS_PER_CYC;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FEED      = 2'd1,
        WAIT_LINE = 2'd2,
        WAIT_OUT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic [BEAT_CW-1:0]   beat_q, beat_d;
    logic [LINES_W-1:0]   line_cnt_q, line_cnt_d;
    logic [LINES_W-1:0]   num_lines_q, num_lines_d;
`ifdef RS_IN_PREFETCH_EN
    logic [LINE_W-1:0]    buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [LINES_W-1:0]   lines_acc_q, lines_acc_d;
`endif

    logic rdy_c, start_c, val_c, last_c, done_c;
    logic last_beat, last_line;

    assign last_beat = (beat_q == BEAT_CW'(BEATS - 1));
    assign last_line = (line_cnt_q == num_lines_q - LINES_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            line_q      <= '0;
            beat_q      <= '0;
            line_cnt_q  <= '0;
            num_lines_q <= '0;
`ifdef RS_IN_PREFETCH_EN
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            lines_acc_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            line_cnt_q  <= line_cnt_d;
            num_lines_q <= num_lines_d;
`ifdef RS_IN_PREFETCH_EN
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            lines_acc_q <= lines_acc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        beat_d      = beat_q;
        line_cnt_d  = line_cnt_q;
        num_lines_d = num_lines_q;
`ifdef RS_IN_PREFETCH_EN
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        lines_acc_d = lines_acc_q;
`endif
        rdy_c   = 1'b0;
        start_c = 1'b0;
        val_c   = 1'b0;
        last_c  = 1'b0;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                rdy_c = 1'b1;
                if (src_line_val) begin
                    line_d      = src_line_data;
                    num_lines_d = (cfg_num_lines == '0) ? LINES_W'(1) : cfg_num_lines;
                    start_c     = 1'b1;
                    beat_d      = '0;
                    line_cnt_d  = '0;
`ifdef RS_IN_PREFETCH_EN
                    buf_full_d  = 1'b0;
                    lines_acc_d = LINES_W'(1);
`endif
                    state_d     = FEED;
                end
            end

            FEED: begin
                val_c  = 1'b1;
                last_c = last_beat && last_line;
`ifdef RS_IN_PREFETCH_EN
                rdy_c  = !buf_full_q && (lines_acc_q < num_lines_q);
`endif
                if (enc_data_rdy) begin
                    // The active line is a shift register; the next beat is
                    // always in its top bits and zeros fill from below.
                    line_d = line_q << BEAT_W;
                    if (!last_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        beat_d = '0;
                        if (last_line) begin
                            state_d = WAIT_OUT;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
`ifdef RS_IN_PREFETCH_EN
                            if (buf_full_q) begin
                                line_d     = buf_q;
                                buf_full_d = 1'b0;
                            end else if (src_line_val && rdy_c) begin
                                line_d      = src_line_data;
                                lines_acc_d = lines_acc_q + 1'b1;
                            end else begin
                                state_d = WAIT_LINE;
                            end
`else
                            rdy_c = 1'b1;
                            if (src_line_val) begin
                                line_d = src_line_data;
                            end else begin
                                state_d = WAIT_LINE;
                            end
`endif
                        end
                    end
                end
`ifdef RS_IN_PREFETCH_EN
                // Any line taken outside the direct load on a handover beat
                // parks in the prefetch buffer.
                if (rdy_c && src_line_val && !(enc_data_rdy && last_beat && !last_line)) begin
                    buf_d       = src_line_data;
                    buf_full_d  = 1'b1;
                    lines_acc_d = lines_acc_q + 1'b1;
                end
`endif
            end

            WAIT_LINE: begin
                rdy_c = 1'b1;
                if (src_line_val) begin
                    line_d  = src_line_data;
                    beat_d  = '0;
`ifdef RS_IN_PREFETCH_EN
                    lines_acc_d = lines_acc_q + 1'b1;
`endif
                    state_d = FEED;
                end
            end

            WAIT_OUT: begin
                done_c = 1'b1;
                if (out_done) begin
                    state_d = IDLE;
                end
            end

            default: begin
                rdy_c   = 1'bx;
                start_c = 1'bx;
                val_c   = 1'bx;
                last_c  = 1'bx;
                done_c  = 1'bx;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is asserted, not just
    // from the next edge.
    assign src_line_rdy  = rst_n & rdy_c;
    assign enc_start     = rst_n & start_c;
    assign enc_data_val  = rst_n & val_c;
    assign enc_data_last = rst_n & last_c;
    assign in_done       = rst_n & done_c;
    assign enc_data      = line_q[LINE_W-1 -: BEAT_W];

endmodule

// File: tb/tb_rs_encode_in_sequencer.sv
module tb_rs_encode_in_sequencer;

    localparam int LW    = 32;
    localparam int SW    = 8;
    localparam int SPC   = 1;
    localparam int LNW   = 8;
    localparam int BW    = SW * SPC;
    localparam int BEATS = LW / BW;

    logic           clk;
    logic           rst_n;
    logic           src_line_val;
    logic [LW-1:0]  src_line_data;
    logic           src_line_rdy;
    logic [LNW-1:0] cfg_num_lines;
    logic           enc_start;
    logic           enc_data_val;
    logic           enc_data_rdy;
    logic [BW-1:0]  enc_data;
    logic           enc_data_last;
    logic           in_done;
    logic           out_done;

    int tests_run = 0;
    int fails = 0;

    rs_encode_in_sequencer #(
        .LINE_W(LW), .SYM_W(SW), .SYMS_PER_CYC(SPC), .LINES_W(LNW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_line_val(src_line_val), .src_line_data(src_line_data), .src_line_rdy(src_line_rdy),
        .cfg_num_lines(cfg_num_lines),
        .enc_start(enc_start), .enc_data_val(enc_data_val), .enc_data_rdy(enc_data_rdy),
        .enc_data(enc_data), .enc_data_last(enc_data_last),
        .in_done(in_done), .out_done(out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a codeword is a list of accepted lines; each accepted
    // line contributes BEATS expected beats (MSB-first slices), the final beat
    // of line num-1 carrying last.
    typedef struct {
        logic [BW-1:0] d;
        bit            last;
    } sym_t;

    sym_t exp_q[$];
    bit   m_busy = 0;
    int   m_acc = 0;
    int   m_num = 0;
    int   m_sz;
    bit   m_rdy, m_done, m_start;
    sym_t m_s;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 0;
            m_acc  = 0;
            m_num  = 0;
        end else begin
            m_sz = exp_q.size();
            tests_run++;
            if (enc_data_val !== (m_sz != 0)) begin
                fails++;
                $display("FAIL mon_val: got %b want %b at %0t", enc_data_val, (m_sz != 0), $time);
            end
`ifdef RS_IN_PREFETCH_EN
            m_rdy = !m_busy || (m_acc < m_num && m_sz <= BEATS);
`else
            m_rdy = !m_busy || (m_acc < m_num && (m_sz == 0 || (m_sz == 1 && enc_data_rdy)));
`endif
            tests_run++;
            if (src_line_rdy !== m_rdy) begin
                fails++;
                $display("FAIL mon_rdy: got %b want %b at %0t", src_line_rdy, m_rdy, $time);
            end
            m_done = m_busy && (m_acc == m_num) && (m_sz == 0);
            tests_run++;
            if (in_done !== m_done) begin
                fails++;
                $display("FAIL mon_in_done: got %b want %b at %0t", in_done, m_done, $time);
            end
            if (m_sz != 0) begin
                tests_run++;
                if (enc_data !== exp_q[0].d || enc_data_last !== exp_q[0].last) begin
                    fails++;
                    $display("FAIL mon_beat: got %h/%b want %h/%b at %0t",
                             enc_data, enc_data_last, exp_q[0].d, exp_q[0].last, $time);
                end
                if (enc_data_val && enc_data_rdy) m_s = exp_q.pop_front();
            end else begin
                tests_run++;
                if (enc_data_last !== 1'b0) begin
                    fails++;
                    $display("FAIL mon_last_idle: got %b want 0 at %0t", enc_data_last, $time);
                end
            end
            m_start = src_line_val && src_line_rdy && !m_busy;
            tests_run++;
            if (enc_start !== m_start) begin
                fails++;
                $display("FAIL mon_start: got %b want %b at %0t", enc_start, m_start, $time);
            end
            if (src_line_val && src_line_rdy) begin
                if (!m_busy) begin
                    m_busy = 1;
                    m_acc  = 0;
                    m_num  = (cfg_num_lines == 0) ? 1 : int'(cfg_num_lines);
                end
                for (int b = 0; b < BEATS; b++) begin
                    m_s.d    = src_line_data[LW-1-b*BW -: BW];
                    m_s.last = (m_acc == m_num - 1) && (b == BEATS - 1);
                    exp_q.push_back(m_s);
                end
                m_acc++;
            end
            if (out_done && in_done) m_busy = 0;
        end
    end

    // Offers filler lines until the open codeword (if any) completes, then
    // pulses out_done and leaves the inputs idle.
    task automatic drain_cw();
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            enc_data_rdy  = 1'b1;
            cfg_num_lines = 8'd1;
            if (in_done) begin
                out_done     = 1'b1;
                src_line_val = 1'b0;
                done         = 1;
            end else begin
                out_done      = 1'b0;
                src_line_val  = 1'b1;
                src_line_data = $urandom;
            end
        end
        @(negedge clk);
        out_done     = 1'b0;
        src_line_val = 1'b0;
        #2;
        tests_run++;
        if (!done || src_line_rdy !== 1'b1) begin
            fails++;
            $display("FAIL drain_idle: done %0d rdy %b want done 1 rdy 1", done, src_line_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        src_line_val  = 1'b1;
        src_line_data = 32'h12345678;
        cfg_num_lines = 8'd1;
        enc_data_rdy  = 1'b1;
        out_done      = 1'b0;
        @(negedge clk);
        #2;
        tests_run++;
        if ({src_line_rdy, enc_start, enc_data_val, enc_data_last, in_done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {src_line_rdy, enc_start, enc_data_val, enc_data_last, in_done});
        end
        tests_run++;
        if (enc_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h want 00", enc_data);
        end
        @(negedge clk);
        src_line_val = 1'b0;
        rst_n        = 1'b1;
        #2;
        tests_run++;
        if (src_line_rdy !== 1'b1 || enc_data_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: rdy %b val %b want 1 0", src_line_rdy, enc_data_val);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b[4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = 32'hAABBCCDD;
        cfg_num_lines = 8'd1;
        enc_data_rdy  = 1'b1;
        #2;
        tests_run++;
        if (enc_start !== 1'b1) begin
            fails++;
            $display("FAIL single_start: got %b want 1", enc_start);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            src_line_val = 1'b0;
            #2;
            tests_run++;
            if (enc_data !== exp_b[c-1] || enc_data_last !== (c == 4) || enc_data_val !== 1'b1) begin
                fails++;
                $display("FAIL single_beat%0d: got %h last %b val %b want %h last %b val 1",
                         c, enc_data, enc_data_last, enc_data_val, exp_b[c-1], (c == 4));
            end
        end
        @(negedge clk);
        #2;
        tests_run++;
        if (in_done !== 1'b1) begin
            fails++;
            $display("FAIL single_in_done: got %b want 1", in_done);
        end
        drain_cw();
    endtask

    task automatic test_back_to_back();
        int  starts = 0;
        bit  taken = 0;
        logic [LW-1:0] l1;
        l1 = $urandom;
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = $urandom;
        cfg_num_lines = 8'd2;
        enc_data_rdy  = 1'b1;
        #2;
        if (enc_start) starts++;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            src_line_val  = !taken;
            src_line_data = l1;
            #2;
            tests_run++;
            if (enc_data_val !== 1'b1) begin
                fails++;
                $display("FAIL b2b_gap: cycle %0d val %b want 1", c, enc_data_val);
            end
            if (enc_start) starts++;
            if (src_line_val && src_line_rdy) taken = 1;
        end
        @(negedge clk);
        src_line_val = 1'b0;
        #2;
        tests_run++;
        if (starts != 1 || !taken || in_done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_summary: starts %0d taken %0d in_done %b want 1 1 1", starts, taken, in_done);
        end
        drain_cw();
    endtask

    task automatic test_wait_line();
        logic [LW-1:0] l1;
        logic [BW-1:0] top;
        l1  = $urandom;
        top = l1[LW-1 -: BW];
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = $urandom;
        cfg_num_lines = 8'd2;
        enc_data_rdy  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            src_line_val = 1'b0;
        end
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            src_line_val  = (c == 7);
            src_line_data = l1;
            #2;
            tests_run++;
            if (enc_data_val !== 1'b0 || src_line_rdy !== 1'b1) begin
                fails++;
                $display("FAIL wait_line_c%0d: val %b rdy %b want 0 1", c, enc_data_val, src_line_rdy);
            end
        end
        @(negedge clk);
        src_line_val = 1'b0;
        #2;
        tests_run++;
        if (enc_data_val !== 1'b1 || enc_data !== top) begin
            fails++;
            $display("FAIL wait_line_resume: val %b data %h want 1 %h", enc_data_val, enc_data, top);
        end
        drain_cw();
    endtask

    task automatic test_stall();
        logic [LW-1:0] l;
        logic [BW-1:0] want;
        l    = $urandom;
        want = l[LW-1-BW -: BW];
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = l;
        cfg_num_lines = 8'd1;
        enc_data_rdy  = 1'b1;
        @(negedge clk);
        src_line_val = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            enc_data_rdy = (c == 4);
            #2;
            tests_run++;
            if (enc_data !== want || enc_data_val !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold_c%0d: data %h val %b want %h 1", c, enc_data, enc_data_val, want);
            end
        end
        drain_cw();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = 32'hAABBCCDD;
        cfg_num_lines = 8'd1;
        enc_data_rdy  = 1'b1;
        @(negedge clk);
        src_line_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        tests_run++;
        if (enc_data !== 8'hCC) begin
            fails++;
            $display("FAIL rstmid_beat2: got %h want cc", enc_data);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({src_line_rdy, enc_start, enc_data_val, enc_data_last, in_done} !== 5'b0 || enc_data !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_outputs: ctrl %b data %h want 00000 00",
                     {src_line_rdy, enc_start, enc_data_val, enc_data_last, in_done}, enc_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        tests_run++;
        if (src_line_rdy !== 1'b1 || enc_data_val !== 1'b0 || in_done !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_idle: rdy %b val %b done %b want 1 0 0", src_line_rdy, enc_data_val, in_done);
        end
        test_single();
    endtask

`ifdef RS_IN_PREFETCH_EN
    task automatic test_prefetch();
        logic [LW-1:0] lines[3];
        int idx = 1;
        for (int i = 0; i < 3; i++) lines[i] = $urandom;
        @(negedge clk);
        src_line_val  = 1'b1;
        src_line_data = lines[0];
        cfg_num_lines = 8'd3;
        enc_data_rdy  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            src_line_val  = (idx < 3);
            src_line_data = lines[(idx < 3) ? idx : 2];
            #2;
            tests_run++;
            if (enc_data_val !== 1'b1) begin
                fails++;
                $display("FAIL pf_gap: cycle %0d val %b want 1", c, enc_data_val);
            end
            if (c == 2) begin
                tests_run++;
                if (src_line_rdy !== 1'b0) begin
                    fails++;
                    $display("FAIL pf_full_rdy: got %b want 0", src_line_rdy);
                end
            end
            if (src_line_val && src_line_rdy) idx++;
        end
        @(negedge clk);
        src_line_val = 1'b0;
        #2;
        tests_run++;
        if (idx != 3 || in_done !== 1'b1) begin
            fails++;
            $display("FAIL pf_summary: lines %0d in_done %b want 3 1", idx, in_done);
        end
        drain_cw();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            src_line_val  = ($urandom_range(0, 2) != 0);
            src_line_data = $urandom;
            cfg_num_lines = LNW'($urandom_range(0, 4));
            enc_data_rdy  = ($urandom_range(0, 3) != 0);
            out_done      = ($urandom_range(0, 3) == 0);
        end
        drain_cw();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_line();
        test_stall();
        test_reset_mid();
`ifdef RS_IN_PREFETCH_EN
        test_prefetch();
`endif
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
